mips_multicycle_ctrl: RTL and testbench

Parametrised multi-cycle control unit. It is the successor to the single-cycle MIPS top-level control path. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and stalls on a variable-latency memory using a ready handshake. It also provides wait-timeout detection, illegal-opcode flagging and cycle/retired-instruction counters. It drives the shared ALU, register file, IR and PC enables of the multi-cycle datapath.

---
 rtl/mips_multicycle_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with memory-ready stalls,
// wait timeout, sticky error flags and cycle/retire counters. Optional bne support: MIPS_MC_BNE_EN.
module mips_multicycle_ctrl #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned STATE_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
`ifdef MIPS_MC_BNE_EN
  output logic               PCWriteCondN,
`endif
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               ALUSrcA,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUOp,
  output logic [1:0]         ALUSrcB,
  output logic [STATE_W-1:0] state,
  output logic               illegal_op,
  output logic               mem_err,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instr_cnt
);

  localparam int unsigned WaitW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
`ifdef MIPS_MC_BNE_EN
  localparam logic [5:0] OpBne   = 6'h05;
`endif

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StRwb    = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
    StAddiEx = 4'd10,
    StAddiWb = 4'd11,
    StHalt   = 4'd15
  } state_e;

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic               illegal_q, illegal_d;
  logic               mem_err_q, mem_err_d;
  logic [CNT_W-1:0]   cycle_q, instr_q;
  logic               retire;
  logic               wait_inc;

  // funct is decoded by the ALU control; zero only matters when bne support is built in.
  logic unused_inputs;
`ifdef MIPS_MC_BNE_EN
  assign unused_inputs = ^funct;
`else
  assign unused_inputs = ^{funct, zero};
`endif

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    illegal_d = illegal_q;
    mem_err_d = mem_err_q;
    retire    = 1'b0;
    wait_inc  = 1'b0;
    case (state_q)
      StFetch: begin
        if (mem_ready) state_d = StDecode;
        else           wait_inc = 1'b1;
      end
      StDecode: begin
        case (opcode)
          OpRtype:     state_d = StExec;
          OpLw, OpSw:  state_d = StMemAdr;
          OpBeq:       state_d = StBranch;
`ifdef MIPS_MC_BNE_EN
          OpBne:       state_d = StBranch;
`endif
          OpJ:         state_d = StJump;
          OpAddi:      state_d = StAddiEx;
          default: begin
            illegal_d = 1'b1;
            state_d   = StFetch;
          end
        endcase
      end
      StMemAdr: state_d = (opcode == OpSw) ? StMemWr : StMemRd;
      StMemRd: begin
        if (mem_ready) state_d = StMemWb;
        else           wait_inc = 1'b1;
      end
      StMemWr: begin
        if (mem_ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end else begin
          wait_inc = 1'b1;
        end
      end
      StMemWb, StRwb, StBranch, StJump, StAddiWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StExec:   state_d = StRwb;
      StAddiEx: state_d = StAddiWb;
      StHalt:   state_d = StHalt;
      default:  state_d = StFetch;
    endcase

    // Only reached while mem_ready is low, so a ready on the limit cycle always wins.
    if (wait_inc && (MEM_TIMEOUT != 0)) begin
      wait_d = wait_q + 1'b1;
      if ((32'(wait_q) + 32'd1) == MEM_TIMEOUT) begin
        mem_err_d = 1'b1;
        state_d   = StHalt;
      end
    end
    if (state_d != state_q) wait_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StFetch;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
      cycle_q   <= '0;
      instr_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      mem_err_q <= mem_err_d;
      if (state_q != StHalt) cycle_q <= cycle_q + 1'b1;
      if (retire)            instr_q <= instr_q + 1'b1;
    end
  end

  // Moore decode of the current state; FETCH also gates IR/PC loads with mem_ready.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
`ifdef MIPS_MC_BNE_EN
    PCWriteCondN = 1'b0;
`endif
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    ALUSrcA  = 1'b0;
    PCSource = 2'b00;
    ALUOp    = 2'b00;
    ALUSrcB  = 2'b00;
    case (state_q)
      StFetch: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      StDecode: ALUSrcB = 2'b11;
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      StMemWr: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      StMemWb: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      StExec: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      StRwb: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      StBranch: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b01;
        PCSource = 2'b01;
`ifdef MIPS_MC_BNE_EN
        PCWriteCondN = (opcode == OpBne);
        PCWriteCond  = (opcode == OpBne) ? ~zero : zero;
`else
        PCWriteCond  = 1'b1;
`endif
      end
      StJump: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StAddiWb: RegWrite = 1'b1;
      default: ;
    endcase
  end

  assign state      = STATE_W'(state_q);
  assign illegal_op = illegal_q;
  assign mem_err    = mem_err_q;
  assign cycle_cnt  = cycle_q;
  assign instr_cnt  = instr_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: stimulus queues expected per-cycle state, controls,
// counters and flags; a negedge monitor pops and compares.
module tb_mips_multicycle_ctrl;

  logic        clk;
  logic        rst;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic        RegWrite, RegDst, ALUSrcA;
`ifdef MIPS_MC_BNE_EN
  logic        PCWriteCondN;
`endif
  logic [1:0]  PCSource, ALUOp, ALUSrcB;
  logic [3:0]  state;
  logic        illegal_op, mem_err;
  logic [31:0] cycle_cnt, instr_cnt;

  mips_multicycle_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
`ifdef MIPS_MC_BNE_EN
    .PCWriteCondN(PCWriteCondN),
`endif
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .IRWrite     (IRWrite),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .ALUSrcA     (ALUSrcA),
    .PCSource    (PCSource),
    .ALUOp       (ALUOp),
    .ALUSrcB     (ALUSrcB),
    .state       (state),
    .illegal_op  (illegal_op),
    .mem_err     (mem_err),
    .cycle_cnt   (cycle_cnt),
    .instr_cnt   (instr_cnt)
  );

  // clk starts high so each entry pushed at posedge+1 is checked at the following negedge.
  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [3:0]  st;
    logic [16:0] ctl;
    logic [31:0] cyc;
    logic [31:0] ic;
    logic        il;
    logic        me;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          step     = 0;
  logic [31:0] exp_cyc  = 0;

  localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4, MW = 4'd5;
  localparam logic [3:0] EX = 4'd6, RWB = 4'd7, BR = 4'd8, JP = 4'd9, AEX = 4'd10, AWB = 4'd11;
  localparam logic [3:0] HL = 4'd15;

  logic [16:0] c_fetch1, c_fetch0, c_decode, c_memadr, c_memrd, c_memwb, c_memwr;
  logic [16:0] c_exec, c_rwb, c_branch, c_branch_n, c_jump, c_addiex, c_addiwb, c_none;

  // Bit order: PCWriteCondN, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
  // RegWrite, RegDst, ALUSrcA, PCSource, ALUOp, ALUSrcB.
  function automatic logic [16:0] mk(input logic n, input logic pcw, input logic pcwc,
                                     input logic iord, input logic mr, input logic mw,
                                     input logic m2r, input logic irw, input logic rw,
                                     input logic rd, input logic asa, input logic [1:0] pcs,
                                     input logic [1:0] aop, input logic [1:0] asb);
    return {n, pcw, pcwc, iord, mr, mw, m2r, irw, rw, rd, asa, pcs, aop, asb};
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t        e;
      logic [16:0] act;
      e = sb.pop_front();
`ifdef MIPS_MC_BNE_EN
      act = {PCWriteCondN, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
             RegWrite, RegDst, ALUSrcA, PCSource, ALUOp, ALUSrcB};
`else
      act = {1'b0, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
             RegWrite, RegDst, ALUSrcA, PCSource, ALUOp, ALUSrcB};
`endif
      checks += 6;
      if (state !== e.st) begin
        failures++;
        $display("FAIL step %0d state: got %0d want %0d", e.id, state, e.st);
      end
      if (act !== e.ctl) begin
        failures++;
        $display("FAIL step %0d ctrl: got %05h want %05h", e.id, act, e.ctl);
      end
      if (cycle_cnt !== e.cyc) begin
        failures++;
        $display("FAIL step %0d cycle_cnt: got %0d want %0d", e.id, cycle_cnt, e.cyc);
      end
      if (instr_cnt !== e.ic) begin
        failures++;
        $display("FAIL step %0d instr_cnt: got %0d want %0d", e.id, instr_cnt, e.ic);
      end
      if (illegal_op !== e.il) begin
        failures++;
        $display("FAIL step %0d illegal_op: got %0b want %0b", e.id, illegal_op, e.il);
      end
      if (mem_err !== e.me) begin
        failures++;
        $display("FAIL step %0d mem_err: got %0b want %0b", e.id, mem_err, e.me);
      end
    end
  end

  task automatic cyc(input logic r, input logic [5:0] op, input logic rdy, input logic z,
                     input logic [3:0] st, input logic [16:0] ctl, input logic [31:0] ic,
                     input logic il, input logic me);
    exp_t e;
    rst       = r;
    opcode    = op;
    mem_ready = rdy;
    zero      = z;
    if (!r) exp_cyc = 0;
    step++;
    e.id  = step;
    e.st  = st;
    e.ctl = ctl;
    e.cyc = exp_cyc;
    e.ic  = ic;
    e.il  = il;
    e.me  = me;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (r && st != HL) exp_cyc++;
  endtask

  initial begin
    c_fetch1   = mk(0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b01);
    c_fetch0   = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01);
    c_decode   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11);
    c_memadr   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b10);
    c_memrd    = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    c_memwb    = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00);
    c_memwr    = mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    c_exec     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00);
    c_rwb      = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00);
    c_branch   = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b01, 2'b00);
    c_branch_n = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b01, 2'b00);
    c_jump     = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00);
    c_addiex   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b10);
    c_addiwb   = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00);
    c_none     = '0;

    rst = 1'b1; opcode = '0; funct = 6'h20; zero = 1'b0; mem_ready = 1'b0;
    #1;
    cyc(0, 6'h00, 0, 0, F, c_fetch0, 0, 0, 0);

    // lw up to MEMRD, then reset mid-instruction
    cyc(1, 6'h23, 1, 0, F,  c_fetch1, 0, 0, 0);
    cyc(1, 6'h23, 1, 0, D,  c_decode, 0, 0, 0);
    cyc(1, 6'h23, 1, 0, MA, c_memadr, 0, 0, 0);
    cyc(1, 6'h23, 0, 0, MR, c_memrd,  0, 0, 0);
    cyc(0, 6'h23, 0, 0, F,  c_fetch0, 0, 0, 0);

    // R-type
    cyc(1, 6'h00, 1, 0, F,   c_fetch1, 0, 0, 0);
    cyc(1, 6'h00, 1, 0, D,   c_decode, 0, 0, 0);
    cyc(1, 6'h00, 1, 0, EX,  c_exec,   0, 0, 0);
    cyc(1, 6'h00, 1, 0, RWB, c_rwb,    0, 0, 0);

    // lw with three stall cycles in MEMRD
    cyc(1, 6'h23, 1, 0, F,   c_fetch1, 1, 0, 0);
    cyc(1, 6'h23, 1, 0, D,   c_decode, 1, 0, 0);
    cyc(1, 6'h23, 1, 0, MA,  c_memadr, 1, 0, 0);
    cyc(1, 6'h23, 0, 0, MR,  c_memrd,  1, 0, 0);
    cyc(1, 6'h23, 0, 0, MR,  c_memrd,  1, 0, 0);
    cyc(1, 6'h23, 0, 0, MR,  c_memrd,  1, 0, 0);
    cyc(1, 6'h23, 1, 0, MR,  c_memrd,  1, 0, 0);
    cyc(1, 6'h23, 1, 0, MWB, c_memwb,  1, 0, 0);

    // sw with one stall cycle
    cyc(1, 6'h2B, 1, 0, F,  c_fetch1, 2, 0, 0);
    cyc(1, 6'h2B, 1, 0, D,  c_decode, 2, 0, 0);
    cyc(1, 6'h2B, 1, 0, MA, c_memadr, 2, 0, 0);
    cyc(1, 6'h2B, 0, 0, MW, c_memwr,  2, 0, 0);
    cyc(1, 6'h2B, 1, 0, MW, c_memwr,  2, 0, 0);

    // beq taken
    cyc(1, 6'h04, 1, 1, F,  c_fetch1, 3, 0, 0);
    cyc(1, 6'h04, 1, 1, D,  c_decode, 3, 0, 0);
    cyc(1, 6'h04, 1, 1, BR, c_branch, 3, 0, 0);

    // j
    cyc(1, 6'h02, 1, 0, F,  c_fetch1, 4, 0, 0);
    cyc(1, 6'h02, 1, 0, D,  c_decode, 4, 0, 0);
    cyc(1, 6'h02, 1, 0, JP, c_jump,   4, 0, 0);

    // addi
    cyc(1, 6'h08, 1, 0, F,   c_fetch1, 5, 0, 0);
    cyc(1, 6'h08, 1, 0, D,   c_decode, 5, 0, 0);
    cyc(1, 6'h08, 1, 0, AEX, c_addiex, 5, 0, 0);
    cyc(1, 6'h08, 1, 0, AWB, c_addiwb, 5, 0, 0);

    // undefined opcode: flag set, not retired
    cyc(1, 6'h3F, 1, 0, F, c_fetch1, 6, 0, 0);
    cyc(1, 6'h3F, 1, 0, D, c_decode, 6, 0, 0);
    cyc(1, 6'h3F, 1, 0, F, c_fetch1, 6, 1, 0);

    // bne after a fresh reset
    cyc(0, 6'h05, 1, 0, F, c_fetch1, 0, 0, 0);
    cyc(1, 6'h05, 1, 0, F, c_fetch1, 0, 0, 0);
    cyc(1, 6'h05, 1, 0, D, c_decode, 0, 0, 0);
`ifdef MIPS_MC_BNE_EN
    cyc(1, 6'h05, 1, 0, BR, c_branch_n, 0, 0, 0);
    cyc(1, 6'h05, 1, 0, F,  c_fetch1,   1, 0, 0);
`else
    cyc(1, 6'h05, 1, 0, F, c_fetch1, 0, 1, 0);
`endif

    // fetch timeout: 15 waiting cycles, then HALT with frozen cycle count
    cyc(0, 6'h00, 0, 0, F, c_fetch0, 0, 0, 0);
    for (int i = 0; i < 15; i++) cyc(1, 6'h00, 0, 0, F, c_fetch0, 0, 0, 0);
    for (int i = 0; i < 3; i++)  cyc(1, 6'h00, 1, 0, HL, c_none, 0, 0, 1);

    for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
    #2;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
